cond_logic: RTL and testbench

Conditional-execution unit for the ARM-style single-cycle/multicycle processor datapath. It sits between the control decoder and the datapath write enables. It evaluates the instruction's 4-bit condition field against the current architectural flags and gates the PC-source, register-write and memory-write requests. It also produces the next NZCV flag state, held in an internal register.

---
 rtl/cond_logic_pkg.sv | 33 +++
 rtl/cond_logic_check.sv | 49 ++++
 rtl/cond_logic.sv | 71 +++++++
 tb/tb_cond_logic.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cond_logic_pkg.sv
// cond_logic_pkg: shared types and constants for the conditional-execution unit.
//   cond_e  - the 16 ARM condition-field encodings (instruction bits [31:28])
//   FLAG_*  - bit positions of N, Z, C and V inside a flags_t word
//   flags_t - architectural flag word {N,Z,C,V}
package cond_logic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_logic_check.sv
// cond_check: combinational evaluation of an instruction condition field.
// Ports:
//   Cond   in  4  condition field
//   flags  in  4  current architectural flags {N,Z,C,V}
//   CondEx out 1  condition passed
// Build option: COND_NV_EN makes Cond=1111 unconditional; otherwise it is "never".
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] Cond,
  input  flags_t     flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
`ifdef COND_NV_EN
      COND_NV: CondEx = 1'b1;
`else
      COND_NV: CondEx = 1'b0;
`endif
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// cond_logic: conditional-execution unit between the control decoder and the
// datapath write enables. Gates PC/register/memory writes by the condition
// result and holds the NZCV flag register.
// Ports:
//   clk       in  1  clock, rising edge
//   reset     in  1  synchronous active-low reset
//   Cond      in  4  instruction condition field
//   ALUFlags  in  4  ALU result flags {N,Z,C,V}
//   prevFlags in  4  current architectural flags used for evaluation
//   FlagW     in  2  [1] update N,Z; [0] update C,V
//   PCS/RegW/MemW in 1  decoder write requests
//   PCSrc/RegWrite/MemWrite out 1  gated write enables (0 while reset is low)
//   CondEx    out 1  condition passed
//   FlagsX    out 4  registered flags {N,Z,C,V}
// Build option: COND_NV_EN (see cond_check) selects the meaning of Cond=1111.
module cond_logic
  import cond_logic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] prevFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] FlagsX
);

  flags_t flags_d, flags_q;
  logic   cond_ex;

  cond_check u_cond_check (
    .Cond   (Cond),
    .flags  (prevFlags),
    .CondEx (cond_ex)
  );

  assign CondEx = cond_ex;

  // Enables are held low combinationally for the whole time reset is asserted.
  assign PCSrc    = PCS  & cond_ex & reset;
  assign RegWrite = RegW & cond_ex & reset;
  assign MemWrite = MemW & cond_ex & reset;

  // A failed condition reloads prevFlags, so flags never change on a skipped op.
  always_comb begin
    flags_d = prevFlags;
    if (FlagW[1] && cond_ex) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0] && cond_ex) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign FlagsX = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags, prevFlags, FlagsX;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, PCSrc, RegWrite, MemWrite, CondEx;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef COND_NV_EN
  localparam bit NV_PASS = 1'b1;
`else
  localparam bit NV_PASS = 1'b0;
`endif

  cond_logic dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .prevFlags (prevFlags),
    .FlagW     (FlagW),
    .PCS       (PCS),
    .RegW      (RegW),
    .MemW      (MemW),
    .PCSrc     (PCSrc),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .CondEx    (CondEx),
    .FlagsX    (FlagsX)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond, prev, alu;
    logic [1:0] fw;
    logic       pcs, regw, memw;
    logic       e_cex, e_pc, e_rw, e_mw;
    logic [3:0] e_flags;
  } vec_t;

  // Reference: odd encodings are the negation of the preceding even one,
  // except the 111x pair (AL / NV).
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return c[0] ? NV_PASS : 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] p,
                       input logic [3:0] a, input logic [1:0] fw,
                       input logic pcs, input logic rw, input logic mw);
    reset = rst; Cond = c; prevFlags = p; ALUFlags = a; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[7];

  initial begin
    vec_t       v;
    bit         ce;
    logic [3:0] ef;

    // cond prev alu fw pcs regw memw | cex pc rw mw flags
    vt[0] = '{4'b0000, 4'b0100, 4'b1001, 2'b11, 1, 1, 1, 1, 1, 1, 1, 4'b1001};
    vt[1] = '{4'b0000, 4'b0000, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0, 0, 4'b0000};
    vt[2] = '{4'b1100, 4'b1001, 4'b0110, 2'b01, 0, 0, 0, 1, 0, 0, 0, 4'b1010};
    vt[3] = '{4'b1000, 4'b0110, 4'b1001, 2'b11, 0, 0, 1, 0, 0, 0, 0, 4'b0110};
    vt[4] = '{4'b1001, 4'b0110, 4'b1001, 2'b00, 0, 0, 1, 1, 0, 0, 1, 4'b0110};
    vt[5] = '{4'b1111, 4'b0000, 4'b1111, 2'b11, 0, 1, 0, NV_PASS, 0, NV_PASS, 0,
              NV_PASS ? 4'b1111 : 4'b0000};
    vt[6] = '{4'b1110, 4'b0011, 4'b1100, 2'b10, 1, 0, 0, 1, 1, 0, 0, 4'b1111};

    // Reset for two edges with requests that would otherwise pass and update.
    drive(1'b0, 4'b1110, 4'b0101, 4'b1010, 2'b11, 1, 1, 1);
    tick();
    tick();
    check("rst_flags", FlagsX, 4'b0000);
    check("rst_en", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    check("rst_condex", {3'b0, CondEx}, 4'b0001);

    // Release: the first edge with reset high loads normally.
    reset = 1'b1;
    #1;
    check("rel_en", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);
    tick();
    check("rel_flags", FlagsX, 4'b1010);

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      v = vt[i];
      drive(1'b1, v.cond, v.prev, v.alu, v.fw, v.pcs, v.regw, v.memw);
      #2;
      check($sformatf("tbl%0d_comb", i), {CondEx, PCSrc, RegWrite, MemWrite},
            {v.e_cex, v.e_pc, v.e_rw, v.e_mw});
      tick();
      check($sformatf("tbl%0d_flags", i), FlagsX, v.e_flags);
    end

    // Reset priority over a simultaneous update, then immediate recovery.
    drive(1'b0, 4'b1110, 4'b0000, 4'b1111, 2'b11, 0, 1, 0);
    tick();
    check("rstpri_flags", FlagsX, 4'b0000);
    drive(1'b1, 4'b1110, 4'b0000, 4'b0110, 2'b11, 0, 1, 0);
    tick();
    check("rec_flags", FlagsX, 4'b0110);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
            2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      ce = ref_cond(Cond, prevFlags);
      ef = prevFlags;
      if (FlagW[1] && ce) ef[3:2] = ALUFlags[3:2];
      if (FlagW[0] && ce) ef[1:0] = ALUFlags[1:0];
      if (!reset) ef = 4'b0000;
      #2;
      check("rnd_comb", {CondEx, PCSrc, RegWrite, MemWrite},
            {ce, PCS & ce & reset, RegW & ce & reset, MemW & ce & reset});
      tick();
      check("rnd_flags", FlagsX, ef);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
